gate_test_sequencer: RTL and testbench

Self-checking stimulus controller for the 2-input switch-level gate cells (AndGate and siblings). It drives the gate inputs through all four input combinations, waits a programmable settle interval per vector, samples the gate output and compares it against a parameterised truth table. It records per-vector pass/fail and a mismatch count. It sits between a bench or BIST top level and one gate instance, replacing hand-written `#10` stimulus sequences with a clocked, repeatable sequence.

---
 rtl/gate_test_sequencer.sv | 118 +++++++++++
 tb/tb_gate_test_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/gate_test_sequencer.sv
// Clocked stimulus/checker for a 2-input gate cell: steps {a,b} through 00..11,
// holds each vector for SETTLE_CYCLES, samples c and scores it against TRUTH.
module gate_test_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [3:0]  TRUTH         = 4'b1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       c,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       done_q, done_d;
  logic [2:0] err_count_q, err_count_d;
  logic [3:0] fail_vec_q, fail_vec_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 2'd0;
      cnt_q       <= 4'd0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      done_q      <= 1'b0;
      err_count_q <= 3'd0;
      fail_vec_q  <= 4'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      done_q      <= done_d;
      err_count_q <= err_count_d;
      fail_vec_q  <= fail_vec_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    done_d      = done_q;
    err_count_d = err_count_q;
    fail_vec_d  = fail_vec_q;

    case (state_q)
      IDLE, DONE: begin
        // start while busy never reaches here, so it is ignored by construction
        if (start) begin
          idx_d       = 2'd0;
          a_d         = 1'b0;
          b_d         = 1'b0;
          cnt_d       = 4'd0;
          err_count_d = 3'd0;
          fail_vec_d  = 4'd0;
          done_d      = 1'b0;
          state_d     = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        // Case inequality so an undriven or floating c scores as a mismatch
        if (c !== TRUTH[idx_q]) begin
          fail_vec_d[idx_q] = 1'b1;
          err_count_d       = err_count_q + 3'd1;
        end
        if (idx_q == 2'd3) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d      = idx_q + 2'd1;
          {a_d, b_d} = idx_q + 2'd1;
          cnt_d      = 4'd0;
          state_d    = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign a         = a_q;
  assign b         = b_q;
  assign busy      = (state_q == SETTLE) || (state_q == SAMPLE);
  assign done      = done_q;
  assign pass      = done_q && (err_count_q == 3'd0);
  assign err_count = err_count_q;
  assign fail_vec  = fail_vec_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench for gate_test_sequencer: two instances (S=4 and S=1) driven by a
// behavioural gate model whose function is selected per test.
module tb_gate_test_sequencer;

  localparam int unsigned S0 = 4;
  localparam int unsigned S1 = 1;

  localparam int M_AND  = 0;
  localparam int M_ZERO = 1;
  localparam int M_ONE  = 2;
  localparam int M_OR   = 3;
  localparam int M_NAND = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start0 = 1'b0, start1 = 1'b0;
  logic       c0, c1;
  logic       a0, b0, busy0, done0, pass0;
  logic       a1, b1, busy1, done1, pass1;
  logic [2:0] err0, err1;
  logic [3:0] fv0, fv1;
  int         mode0 = M_AND, mode1 = M_AND;

  int n_checks = 0;
  int n_errors = 0;

  gate_test_sequencer #(.SETTLE_CYCLES(S0), .TRUTH(4'b1000)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .c(c0),
    .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_vec(fv0)
  );

  gate_test_sequencer #(.SETTLE_CYCLES(S1), .TRUTH(4'b1000)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .c(c1),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_vec(fv1)
  );

  function automatic logic gate_model(input int mode, input logic ga, input logic gb);
    case (mode)
      M_AND:   return ga & gb;
      M_ZERO:  return 1'b0;
      M_ONE:   return 1'b1;
      M_OR:    return ga | gb;
      default: return ~(ga & gb);
    endcase
  endfunction

  always_comb c0 = gate_model(mode0, a0, b0);
  always_comb c1 = gate_model(mode1, a1, b1);

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver: one full run with checks ----------------
  task automatic run_seq(input bit use1, input int s, input bit extra_starts,
                         input logic [2:0] exp_err, input logic [3:0] exp_fv);
    int total;
    total = 4 * (s + 1);
    @(negedge clk);
    if (use1) start1 = 1'b1; else start0 = 1'b1;
    tick();  // E0
    start0 = 1'b0;
    start1 = 1'b0;
    check_eq("accept_busy", use1 ? busy1 : busy0, 8'd1);
    check_eq("accept_ab",   use1 ? {a1, b1} : {a0, b0}, 8'd0);
    check_eq("accept_done", use1 ? done1 : done0, 8'd0);
    check_eq("accept_err",  use1 ? err1 : err0, 8'd0);
    check_eq("accept_fv",   use1 ? fv1 : fv0, 8'd0);
    for (int e = 1; e <= total; e++) begin
      if (extra_starts && (e == 3 || e == 12)) begin
        if (use1) start1 = 1'b1; else start0 = 1'b1;
      end
      tick();
      start0 = 1'b0;
      start1 = 1'b0;
      if (e < total && (e % (s + 1)) == 0)
        check_eq("vector_ab", use1 ? {a1, b1} : {a0, b0}, 8'(e / (s + 1)));
      if (e == total - 1) begin
        check_eq("pre_done", use1 ? done1 : done0, 8'd0);
        check_eq("pre_busy", use1 ? busy1 : busy0, 8'd1);
      end
    end
    check_eq("done",     use1 ? done1 : done0, 8'd1);
    check_eq("busy_end", use1 ? busy1 : busy0, 8'd0);
    check_eq("err",      use1 ? err1 : err0, {5'd0, exp_err});
    check_eq("fail_vec", use1 ? fv1 : fv0, {4'd0, exp_fv});
    check_eq("pass",     use1 ? pass1 : pass0, 8'(exp_err == 3'd0));
    repeat (3) tick();
    check_eq("done_hold", use1 ? done1 : done0, 8'd1);
    check_eq("err_hold",  use1 ? err1 : err0, {5'd0, exp_err});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #1;
    check_eq("rst_ab",   {a0, b0}, 8'd0);
    check_eq("rst_busy", busy0, 8'd0);
    check_eq("rst_done", done0, 8'd0);
    check_eq("rst_pass", pass0, 8'd0);
    check_eq("rst_err",  err0, 8'd0);
    check_eq("rst_fv",   fv0, 8'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) tick();
    check_eq("idle_busy", busy0, 8'd0);

    // AND gate, clean run
    mode0 = M_AND;
    run_seq(1'b0, S0, 1'b0, 3'd0, 4'b0000);
    // stuck-at-0 output: only vector 11 mismatches
    mode0 = M_ZERO;
    run_seq(1'b0, S0, 1'b0, 3'd1, 4'b1000);
    // stuck-at-1 output: vectors 00,01,10 mismatch
    mode0 = M_ONE;
    run_seq(1'b0, S0, 1'b0, 3'd3, 4'b0111);
    // rerun with the real gate: results cleared at acceptance
    mode0 = M_AND;
    run_seq(1'b0, S0, 1'b0, 3'd0, 4'b0000);
    // every vector wrong: count reaches 4 without wrapping
    mode0 = M_NAND;
    run_seq(1'b0, S0, 1'b0, 3'd4, 4'b1111);
    // stray starts while busy are ignored
    mode0 = M_AND;
    run_seq(1'b0, S0, 1'b1, 3'd0, 4'b0000);
    // OR behaviour against AND table, S=1
    mode1 = M_OR;
    run_seq(1'b1, S1, 1'b0, 3'd2, 4'b0110);

    // start held high on S=1 instance: done for exactly one cycle
    mode1 = M_AND;
    @(negedge clk);
    start1 = 1'b1;
    tick();  // E0
    repeat (7) tick();
    check_eq("held_pre_done", done1, 8'd0);
    tick();  // E0+8
    check_eq("held_done", done1, 8'd1);
    check_eq("held_pass", pass1, 8'd1);
    tick();  // E0+9: re-accepted
    check_eq("held_redone", done1, 8'd0);
    check_eq("held_rebusy", busy1, 8'd1);
    start1 = 1'b0;
    repeat (10) tick();
    check_eq("held_final_done", done1, 8'd1);

    // reset mid-run at E0+7
    mode0 = M_ONE;
    @(negedge clk);
    start0 = 1'b1;
    tick();  // E0
    start0 = 1'b0;
    repeat (7) tick();
    check_eq("mid_err", err0, 8'd1);
    check_eq("mid_ab",  {a0, b0}, 8'd1);
    rst = 1'b1;
    #1;
    check_eq("arst_ab",   {a0, b0}, 8'd0);
    check_eq("arst_busy", busy0, 8'd0);
    check_eq("arst_err",  err0, 8'd0);
    check_eq("arst_fv",   fv0, 8'd0);
    check_eq("arst_done", done0, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (25) tick();
    check_eq("post_rst_done", done0, 8'd0);
    check_eq("post_rst_busy", busy0, 8'd0);
    check_eq("post_rst_ab",   {a0, b0}, 8'd0);
    check_eq("post_rst_pass", pass0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
